// File: rtl/obc_shift_accumulator_if.sv
// Bus bundle for obc_shift_accumulator.
//   master : frame controller / LUT side (drives start, lut_val, lut_valid)
//   slave  : the accumulator (drives LUT address, status and results)
// Signals:
//   start        frame start request
//   lut_val      signed LUT word for the current (k_idx, i_idx)
//   lut_valid    lut_val usable this cycle, otherwise the step stalls
//   k_idx/i_idx  current bin / bit index (LUT address)
//   busy         accumulating a frame
//   result       final accumulator value of bin result_k
//   result_valid one-cycle pulse per bin
//   done         one-cycle pulse with the last result_valid of a frame
interface obc_shift_accumulator_if #(
    parameter int DATA_W = 32,
    parameter int K_W    = 4,
    parameter int I_W    = 4
);
    logic              start;
    logic [DATA_W-1:0] lut_val;
    logic              lut_valid;
    logic [K_W-1:0]    k_idx;
    logic [I_W-1:0]    i_idx;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic [K_W-1:0]    result_k;
    logic              result_valid;
    logic              done;

    modport master (
        output start, lut_val, lut_valid,
        input  k_idx, i_idx, busy, result, result_k, result_valid, done
    );

    modport slave (
        input  start, lut_val, lut_valid,
        output k_idx, i_idx, busy, result, result_k, result_valid, done
    );
endinterface

// File: rtl/obc_shift_accumulator.sv
// Sequential offset-binary-coding accumulator for the DFT datapath.
// For every bin k it walks bit index i from LSB to MSB, addressing the OBC
// LUT with (k_idx, i_idx). Each step forms a feedback term (offset, zero or
// acc >>> 1), adds the LUT word (or subtracts it on the MSB step when
// MSB_SUB=1) and stores the sum. The last step of a bin publishes the sum
// as result with a result_valid pulse; the last bin also pulses done.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    obc_shift_accumulator_if slave modport (handshake, LUT, results)
module obc_shift_accumulator #(
    parameter int                DATA_W      = 32,
    parameter int                IN_BITS     = 16,
    parameter int                NUM_K       = 16,
    parameter logic [DATA_W-1:0] INIT_OFFSET = 32'hFF00_0000,
    parameter bit                OFFSET_MODE = 1'b0,
    parameter bit                MSB_SUB     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    obc_shift_accumulator_if.slave bus
);
    localparam int K_W = (NUM_K > 1) ? $clog2(NUM_K) : 1;
    localparam int I_W = $clog2(IN_BITS);
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_K - 1);
    localparam logic [I_W-1:0] I_LAST = I_W'(IN_BITS - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [I_W-1:0]    i_q, i_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [K_W-1:0]    result_k_q, result_k_d;
    logic              result_valid_q, result_valid_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] feedback;
    logic [DATA_W-1:0] sum;
    logic              last_bit;

    assign last_bit = (i_q == I_LAST);

    // The first step of a bin never looks at acc, so a previous bin's value
    // cannot leak in; later steps halve acc with the sign bit replicated.
    always_comb begin
        if (i_q == '0) begin
            feedback = ((k_q == '0) || OFFSET_MODE) ? INIT_OFFSET : '0;
        end else begin
            feedback = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
        end
        sum = (MSB_SUB && last_bit) ? feedback - bus.lut_val
                                    : feedback + bus.lut_val;
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        k_d            = k_q;
        i_d            = i_q;
        result_d       = result_q;
        result_k_d     = result_k_q;
        result_valid_d = 1'b0;
        done_d         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    k_d     = '0;
                    i_d     = '0;
                end
            end
            ACCUM: begin
                // lut_valid low stalls the step: every register holds.
                if (bus.lut_valid) begin
                    acc_d = sum;
                    if (last_bit) begin
                        result_d       = sum;
                        result_k_d     = k_q;
                        result_valid_d = 1'b1;
                        i_d            = '0;
                        if (k_q == K_LAST) begin
                            done_d  = 1'b1;
                            k_d     = '0;
                            state_d = IDLE;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            k_q            <= '0;
            i_q            <= '0;
            result_q       <= '0;
            result_k_q     <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            k_q            <= k_d;
            i_q            <= i_d;
            result_q       <= result_d;
            result_k_q     <= result_k_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
        end
    end

    assign bus.k_idx        = k_q;
    assign bus.i_idx        = i_q;
    assign bus.busy         = (state_q == ACCUM);
    assign bus.result       = result_q;
    assign bus.result_k     = result_k_q;
    assign bus.result_valid = result_valid_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Bench for obc_shift_accumulator: three instances share one stimulus
// (0: legacy, 1: MSB_SUB=1, 2: OFFSET_MODE=1) and are checked every cycle
// against a frame-level model, plus literal expectations per scenario.
module tb_obc_shift_accumulator;
    localparam int DW = 32;
    localparam int IB = 4;
    localparam int NK = 2;
    localparam int KW = 1;
    localparam int IW = 2;
    localparam logic [31:0] OFF = 32'hFF00_0000;

    logic clk, rst, start, lut_valid;
    logic [DW-1:0] lut_val;

    logic [KW-1:0] d_k [3];
    logic [IW-1:0] d_i [3];
    logic          d_busy [3];
    logic [DW-1:0] d_res [3];
    logic [KW-1:0] d_rk [3];
    logic          d_rv [3];
    logic          d_done [3];

    for (genvar g = 0; g < 3; g++) begin : gd
        obc_shift_accumulator_if #(.DATA_W(DW), .K_W(KW), .I_W(IW)) bus ();
        assign bus.start     = start;
        assign bus.lut_val   = lut_val;
        assign bus.lut_valid = lut_valid;
        assign d_k[g]    = bus.k_idx;
        assign d_i[g]    = bus.i_idx;
        assign d_busy[g] = bus.busy;
        assign d_res[g]  = bus.result;
        assign d_rk[g]   = bus.result_k;
        assign d_rv[g]   = bus.result_valid;
        assign d_done[g] = bus.done;
        obc_shift_accumulator #(
            .DATA_W(DW), .IN_BITS(IB), .NUM_K(NK), .INIT_OFFSET(OFF),
            .OFFSET_MODE(g == 2), .MSB_SUB(g == 1)
        ) dut (
            .clk_i(clk), .rst_i(rst), .bus(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tot++;
        if (a !== e) $display("FAIL %s: got %h want %h", nm, a, e);
        else n_pass++;
    endtask

    // ---------------- model ----------------
    int            cyc = 0;
    bit            m_busy [3];
    int            m_n [3];
    logic [31:0]   samp [3][IB];
    logic [DW-1:0] e_res [3];
    logic [KW-1:0] e_rk [3];
    logic          e_rv [3];
    logic          e_done [3];
    int            start_cyc [3];
    int            done_cyc [3];
    logic [31:0]   got [3][NK];
    int            done_cnt = 0;

    // One bin from its IN_BITS LUT words, LSB first.
    function automatic logic [31:0] obc_bin(input int d, input int k);
        logic [31:0] a, fb;
        a = 32'h0;
        for (int j = 0; j < IB; j++) begin
            if (j == 0) fb = (k == 0 || d == 2) ? OFF : 32'h0;
            else        fb = 32'($signed(a) >>> 1);
            a = (d == 1 && j == IB - 1) ? fb - samp[d][j] : fb + samp[d][j];
        end
        return a;
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 0; m_n[d] = 0; e_res[d] = '0; e_rk[d] = '0;
            e_rv[d] = 0; e_done[d] = 0; start_cyc[d] = 0; done_cyc[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    m_busy[d] = 0; m_n[d] = 0; e_res[d] = '0; e_rk[d] = '0;
                    e_rv[d] = 0; e_done[d] = 0;
                end else begin
                    e_rv[d] = 0; e_done[d] = 0;
                    if (!m_busy[d]) begin
                        if (start) begin
                            m_busy[d] = 1; m_n[d] = 0; start_cyc[d] = cyc;
                        end
                    end else if (lut_valid) begin
                        samp[d][m_n[d] % IB] = lut_val;
                        if (m_n[d] % IB == IB - 1) begin
                            e_res[d] = obc_bin(d, m_n[d] / IB);
                            e_rk[d]  = KW'(m_n[d] / IB);
                            e_rv[d]  = 1;
                            if (m_n[d] / IB == NK - 1) begin
                                e_done[d] = 1; m_busy[d] = 0;
                            end
                        end
                        m_n[d]++;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [63:0] act, exp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                exp = {25'h0, KW'(m_busy[d] ? m_n[d] / IB : 0),
                       IW'(m_busy[d] ? m_n[d] % IB : 0), m_busy[d],
                       e_res[d], e_rk[d], e_rv[d], e_done[d]};
                act = {25'h0, d_k[d], d_i[d], d_busy[d], d_res[d], d_rk[d],
                       d_rv[d], d_done[d]};
                chk($sformatf("cyc%0d_dut%0d", cyc, d), act, exp);
                if (d_rv[d] === 1'b1) got[d][d_rk[d]] = d_res[d];
                if (d_done[d] === 1'b1) begin
                    done_cyc[d] = cyc;
                    if (d == 0) done_cnt++;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_got();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < NK; k++) got[d][k] = 32'hDEAD_BEEF;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit ok = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (d_done[0] === 1'b1) begin ok = 1; break; end
        end
        chk("done_seen", 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_legacy_results(input string tag, input int lat);
        logic [31:0] want [3][NK];
        want[0][0] = 32'h001C_0000; want[0][1] = 32'h003C_0000;
        want[1][0] = 32'hFFDC_0000; want[1][1] = 32'hFFFC_0000;
        want[2][0] = 32'h001C_0000; want[2][1] = 32'h001C_0000;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < NK; k++)
                chk($sformatf("%s_res_d%0d_k%0d", tag, d, k), 64'(got[d][k]), 64'(want[d][k]));
            chk($sformatf("%s_latency_d%0d", tag, d), 64'(done_cyc[d] - start_cyc[d]), 64'(lat));
        end
    endtask

    initial begin
        int stalls, dc0;
        bit found;
        rst = 1'b1; start = 1'b1; lut_valid = 1'b0; lut_val = '0;
        clear_got();

        // reset with start asserted
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(d_busy[0]), 64'd0);
        chk("rst_result", 64'(d_res[0]), 64'd0);
        chk("rst_idx", 64'({d_k[0], d_i[0], d_rv[0], d_done[0]}), 64'd0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start", 64'(d_busy[0]), 64'd0);

        // legacy frame, lut_val constant, no stalls
        lut_val = 32'h0020_0000; lut_valid = 1'b1;
        pulse_start();
        wait_done(40);
        check_legacy_results("plain", 1 + NK * IB);

        // stall pattern 1,0,0,1,0,0...
        clear_got();
        pulse_start();
        stalls = 0;
        for (int p = 0; p < 100; p++) begin
            @(negedge clk);
            if (d_done[0] === 1'b1) break;
            lut_valid = (p % 3 == 0);
            if (!lut_valid) stalls++;
        end
        lut_valid = 1'b1;
        @(negedge clk);
        check_legacy_results("stall", 1 + NK * IB + stalls);

        // start pulsed while busy is ignored
        clear_got();
        dc0 = done_cnt;
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(40);
        check_legacy_results("busy_start", 1 + NK * IB);
        repeat (4) @(negedge clk);
        chk("busy_start_one_done", 64'(done_cnt - dc0), 64'd1);
        chk("busy_start_idle", 64'(d_busy[0]), 64'd0);

        // random LUT words and random stalls, model-checked every cycle
        pulse_start();
        for (int p = 0; p < 200; p++) begin
            lut_val   = $urandom;
            lut_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (d_done[0] === 1'b1) break;
        end
        lut_val = 32'h0020_0000; lut_valid = 1'b1;
        repeat (2) @(negedge clk);

        // reset mid-frame at k=1, i=2
        dc0 = done_cnt;
        pulse_start();
        found = 0;
        for (int c = 0; c < 40; c++) begin
            if (d_k[0] == 1'b1 && d_i[0] == 2'd2) begin found = 1; break; end
            @(negedge clk);
        end
        chk("midframe_reached", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_idx", 64'({d_k[0], d_i[0]}), 64'd0);
        chk("midrst_busy", 64'(d_busy[0]), 64'd0);
        chk("midrst_result", 64'(d_res[0]), 64'd0);
        repeat (12) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("midrst_stays_idle", 64'(d_busy[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/obc_shift_accumulator.md
Name: obc_shift_accumulator

Overview:
- Sequential, parametrised successor to the combinational OBC feedback mux used in the 16-point DFT datapath.
- Walks bit index i (LSB first) and output index k, and drives the OBC LUT address.
- Per step: applies the offset/zero/shift-right feedback, optionally subtracts the MSB term, and accumulates the LUT value.
- Emits one result per k with a valid pulse, and a done pulse at the end of the frame.

Parameters:
- DATA_W, 32: accumulator, LUT value and result width; two's-complement fixed point.
- IN_BITS, 16: input sample bit width, i.e. accumulation steps per k (≥2).
- NUM_K, 16: number of output bins per frame (≥1).
- INIT_OFFSET, 32'hFF00_0000: OBC offset loaded as feedback on the first step (i==0).
- OFFSET_MODE, 0: 0 = offset only for k==0, feedback 0 for other k; 1 = offset for every k.
- MSB_SUB, 0: 1 = the final step (i==IN_BITS-1) computes feedback − lut_val instead of feedback + lut_val.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: frame start request, sampled only in IDLE.
- lut_val, input, DATA_W: signed LUT output for the current (k_idx, i_idx), combinational, same cycle.
- lut_valid, input, 1: lut_val is usable this cycle; when low the step stalls.
- k_idx, output, clog2(NUM_K) (min 1): current bin index / LUT address.
- i_idx, output, clog2(IN_BITS): current bit index / LUT address.
- busy, output, 1: high while in ACCUM.
- result, output, DATA_W: final accumulator value for bin result_k.
- result_k, output, clog2(NUM_K): bin index of result.
- result_valid, output, 1: one-cycle pulse.
- done, output, 1: one-cycle pulse, coincident with the last result_valid.

Behaviour:
- Reset (sync, priority over everything):
  - State IDLE.
  - acc, result, result_k, k_idx, i_idx all 0.
  - busy, result_valid, done all 0.
  - A reset mid-frame abandons the frame; no result or done is emitted.
- FSM, IDLE:
  - start=1 → ACCUM next cycle with i_idx=0, k_idx=0, busy=1.
  - start=0 → stay in IDLE.
- FSM, ACCUM:
  - start is ignored.
  - lut_valid=0 → all registers hold; result_valid and done are 0.
  - lut_valid=1 → one step.
- Feedback per step (combinational):
  - i_idx==0 and (k_idx==0 or OFFSET_MODE==1) → INIT_OFFSET.
  - i_idx==0 otherwise → 0.
  - else → acc >>> 1 (arithmetic; sign bit replicated).
  - A stale acc must never leak into i_idx==0.
- Step sum:
  - MSB_SUB==1 and i_idx==IN_BITS-1 → sum = feedback − lut_val.
  - otherwise → sum = feedback + lut_val.
  - Modulo 2^DATA_W: wrap, no saturation, no overflow flag.
  - acc <= sum.
- Step with i_idx<IN_BITS-1: i_idx++.
- Step with i_idx==IN_BITS-1:
  - result <= sum, result_k <= k_idx, result_valid <= 1 (visible the next cycle).
  - i_idx <= 0.
  - k_idx<NUM_K-1 → k_idx++.
  - k_idx==NUM_K-1 → done <= 1, k_idx <= 0, next state IDLE (busy low in the cycle done is high).
- result/result_k hold their value until the next result_valid. result_valid and done are otherwise 0.
- Latency: with lut_valid held high, the first result_valid is IN_BITS cycles after the first ACCUM cycle. done fires NUM_K·IN_BITS cycles after entering ACCUM; the total from the start sample is 1+NUM_K·IN_BITS cycles.
- start asserted in the same cycle done is high: the FSM is still in ACCUM, so start is ignored. A new start is accepted from the following IDLE cycle.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 → all outputs 0, busy 0, state IDLE. After release with start=0, nothing happens.
- Legacy offset (DATA_W=32, IN_BITS=4, NUM_K=2, OFFSET_MODE=0, MSB_SUB=0, lut_val=0x0020_0000, lut_valid=1):
  - k0 acc sequence 0xFF20_0000, 0xFFB0_0000, 0xFFF8_0000, 0x001C_0000 → result=0x001C_0000, result_k=0.
  - k1 sequence 0x0020_0000, 0x0030_0000, 0x0038_0000 → result 0x003C_0000, result_k=1, with done on the same cycle.
  - Total of 9 cycles from start.
- MSB subtract: same as above with MSB_SUB=1 → k0 result 0xFFDC_0000, k1 result 0xFFFC_0000.
- OFFSET_MODE=1: same as legacy → both bins produce 0x001C_0000.
- Stalls: toggle lut_valid 1,0,0,1,… → acc, i_idx and k_idx freeze while lut_valid is low. Results are identical to the legacy case and delayed by exactly the stall count.
- Disturbances:
  - Assert rst while k_idx=1, i_idx=2 → outputs 0 next cycle, no done.
  - Pulse start while busy → ignored, no restart, sequence unchanged.
